frame_sender: RTL and testbench

- Transmit side of the host link. The receive side toggles a capture-enable level when the host sends sync byte 0xAB.
- This block answers the host with framed data: sync byte 0xAB, then FRAME_LEN sample bytes popped from the capture FIFO, then an 8-bit additive checksum.
- Sits between the capture FIFO read port (rdclk domain) and the UART transmitter. Frames repeat while arm stays high.

---
 rtl/frame_sender_pkg.sv | 26 ++
 rtl/frame_sender.sv | 132 +++++++++++++
 tb/tb_frame_sender.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sender_pkg.sv
// frame_sender_pkg: types and constants shared by the host-link transmit
// side (frame_sender) and the receive side.
//   SYNC_BYTE : frame header byte; the receive side matches the same value.
//   state_t   : frame_sender FSM states.
//   phase_t   : which kind of byte the FSM is currently sending.
package frame_sender_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAB;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    GAP,
    WAITB,
    FETCH,
    LOAD,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    HDR,
    DATA,
    CSUM
  } phase_t;

endpackage

// File: rtl/frame_sender.sv
// frame_sender: answers the host with framed capture data.
// A frame is SYNC_BYTE, FRAME_LEN sample bytes popped from the capture FIFO,
// then the 8-bit wrap-around sum of the sample bytes. Frames repeat while
// arm is high; a frame that has started always runs to completion.
//
// Ports (all in the rdclk domain):
//   rdclk      in   clock
//   nreset     in   synchronous active-low reset (priority over en)
//   en         in   clock enable; 0 holds all state and masks all strobes
//   arm        in   level, 1 = keep sending frames
//   rdempty    in   capture FIFO empty flag
//   rdreq      out  FIFO read strobe, one cycle per byte
//   q          in   FIFO read data, valid the cycle after rdreq
//   tx_busy    in   UART transmitter busy
//   tx_start   out  one-cycle start pulse to the UART
//   tx_byte    out  byte to the UART, held until the UART drops busy
//   active     out  1 while a frame is in progress
//   frame_done out  one-cycle pulse after the checksum byte is accepted
module frame_sender #(
  parameter logic [7:0] SYNC_BYTE = frame_sender_pkg::SYNC_BYTE,
  parameter int         FRAME_LEN = 16,
  parameter int         CNT_W     = 8
) (
  input  logic       rdclk,
  input  logic       nreset,
  input  logic       en,
  input  logic       arm,
  input  logic       rdempty,
  output logic       rdreq,
  input  logic [7:0] q,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic       active,
  output logic       frame_done
);

  import frame_sender_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       csum_q, csum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;

  // Strobes are gated by en so a stalled clock enable can never create or
  // stretch a pulse; each one coincides with the edge that acts on it.
  assign rdreq      = en & (state_q == FETCH) & ~rdempty;
  assign tx_start   = en & (state_q == TX) & ~tx_busy;
  assign active     = (state_q != IDLE);
  assign tx_byte    = tx_byte_q;
  assign frame_done = frame_done_q;

  always_comb begin
    // NOTE: every signal gets a hold default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    phase_d   = phase_q;
    tx_byte_d = tx_byte_q;
    csum_d    = csum_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          tx_byte_d = SYNC_BYTE;
          csum_d    = 8'h00;
          cnt_d     = '0;
          phase_d   = HDR;
          state_d   = TX;
        end
      end
      TX: begin
        if (!tx_busy) state_d = GAP;
      end
      // One dead cycle lets the UART raise busy before WAITB looks at it.
      GAP: state_d = WAITB;
      WAITB: begin
        if (!tx_busy) begin
          if (phase_q == CSUM) begin
            state_d = DONE;
          end else if (phase_q == DATA && cnt_q == LAST_CNT) begin
            tx_byte_d = csum_q;
            phase_d   = CSUM;
            state_d   = TX;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (!rdempty) state_d = LOAD;
      end
      // FIFO is not show-ahead: q carries the byte popped in FETCH.
      LOAD: begin
        tx_byte_d = q;
        csum_d    = csum_q + q;
        cnt_d     = cnt_q + CNT_W'(1);
        phase_d   = DATA;
        state_d   = TX;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    frame_done_d = (state_d == DONE);
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous and checked before en.
  always_ff @(posedge rdclk) begin
    if (!nreset) begin
      state_q      <= IDLE;
      phase_q      <= HDR;
      tx_byte_q    <= 8'h00;
      csum_q       <= 8'h00;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else if (en) begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      tx_byte_q    <= tx_byte_d;
      csum_q       <= csum_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_frame_sender.sv
// tb_frame_sender: self-checking bench for frame_sender (FRAME_LEN=4).
// A FIFO model (queue, no show-ahead) and a UART model (busy for a fixed
// number of cycles per byte) surround the DUT. Every byte the UART accepts
// is logged and compared with a frame built from the sample list:
// header, samples, sum of samples mod 256.
module tb_frame_sender;

  localparam int FL       = 4;
  localparam int BUSY_CYC = 10;

  typedef logic [7:0] bq_t[$];

  logic       rdclk = 1'b0;
  logic       nreset = 1'b0;
  logic       en = 1'b1;
  logic       arm = 1'b0;
  logic       rdempty = 1'b1;
  logic       rdreq;
  logic [7:0] q = 8'h00;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       active;
  logic       frame_done;

  frame_sender #(
    .FRAME_LEN(FL),
    .CNT_W    (8)
  ) dut (
    .rdclk     (rdclk),
    .nreset    (nreset),
    .en        (en),
    .arm       (arm),
    .rdempty   (rdempty),
    .rdreq     (rdreq),
    .q         (q),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .active    (active),
    .frame_done(frame_done)
  );

  always #5 rdclk = ~rdclk;

  int vectors = 0;
  int miscompares = 0;

  // Environment model state and event log.
  bq_t        fifo;
  bq_t        sent;
  int         tx_cycs[$];
  int         rd_cycs[$];
  int         done_cycs[$];
  int         busy_cnt = 0;
  bit         force_busy = 1'b0;
  bit         en_toggle = 1'b0;
  int         cyc = 0;
  int         n_rdreq = 0;
  int         n_tx = 0;
  int         n_done = 0;
  logic [7:0] last_sent = 8'h00;
  logic       prev_rdreq = 1'b0;
  logic       prev_tx = 1'b0;

  // Values sampled at the falling edge, i.e. what the DUT acts on next edge.
  logic       s_rdreq, s_tx_start, s_active, s_done, s_en, s_busy;
  logic [7:0] s_tx_byte;

  // Reference: a frame is header, samples, then their sum modulo 256.
  function automatic bq_t frame_of(bq_t s);
    bq_t f;
    int  total = 0;
    f.push_back(8'hAB);
    foreach (s[i]) begin
      f.push_back(s[i]);
      total += int'(s[i]);
    end
    f.push_back(8'(total % 256));
    return f;
  endfunction

  function automatic bq_t rand_samples(int n);
    bq_t s;
    for (int i = 0; i < n; i++) s.push_back(8'($urandom));
    return s;
  endfunction

  task automatic clear_log();
    fifo.delete();
    sent.delete();
    tx_cycs.delete();
    rd_cycs.delete();
    done_cycs.delete();
    n_rdreq = 0;
    n_tx    = 0;
    n_done  = 0;
    rdempty = 1'b1;
  endtask

  task automatic load_fifo(bq_t s);
    foreach (s[i]) fifo.push_back(s[i]);
    rdempty = (fifo.size() == 0);
  endtask

  // One clock: sample at the falling edge, protocol checks, then let the
  // FIFO and UART models react just after the rising edge.
  task automatic cycle();
    @(negedge rdclk);
    s_rdreq    = rdreq;
    s_tx_start = tx_start;
    s_tx_byte  = tx_byte;
    s_active   = active;
    s_done     = frame_done;
    s_en       = en;
    s_busy     = tx_busy;
    if (s_rdreq === 1'b1 || s_tx_start === 1'b1) begin
      vectors++;
      if (s_rdreq === 1'b1 && s_tx_start === 1'b1) begin
        miscompares++;
        $display("FAIL strobe_overlap rdreq=%b tx_start=%b required not both", s_rdreq, s_tx_start);
      end
      vectors++;
      if (s_en !== 1'b1) begin
        miscompares++;
        $display("FAIL strobe_en rdreq=%b tx_start=%b with en=%b required en=1", s_rdreq, s_tx_start, s_en);
      end
    end
    if (s_rdreq === 1'b1) begin
      vectors++;
      if (prev_rdreq === 1'b1) begin
        miscompares++;
        $display("FAIL rdreq_width rdreq high 2 cycles, required 1");
      end
    end
    if (s_tx_start === 1'b1) begin
      vectors++;
      if (prev_tx === 1'b1 || s_busy === 1'b1) begin
        miscompares++;
        $display("FAIL tx_start_rule prev=%b busy=%b required both 0", prev_tx, s_busy);
      end
    end
    if (busy_cnt > 0 && nreset === 1'b1) begin
      vectors++;
      if (s_tx_byte !== last_sent) begin
        miscompares++;
        $display("FAIL tx_byte_hold got %02h required %02h while busy", s_tx_byte, last_sent);
      end
    end
    @(posedge rdclk);
    #1;
    cyc++;
    if (s_rdreq === 1'b1) begin
      n_rdreq++;
      rd_cycs.push_back(cyc);
      if (fifo.size() > 0) q = fifo.pop_front();
    end
    if (s_tx_start === 1'b1) begin
      n_tx++;
      tx_cycs.push_back(cyc);
      sent.push_back(s_tx_byte);
      last_sent = s_tx_byte;
      busy_cnt  = BUSY_CYC;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    if (s_done === 1'b1) begin
      n_done++;
      done_cycs.push_back(cyc);
    end
    tx_busy    = force_busy || (busy_cnt > 0);
    rdempty    = (fifo.size() == 0);
    prev_rdreq = s_rdreq;
    prev_tx    = s_tx_start;
    if (en_toggle) en = ~en;
  endtask

  task automatic run_until_done(input int target, input int limit, output bit ok);
    int g = 0;
    while (n_done < target && g < limit) begin
      cycle();
      g++;
    end
    ok = (n_done >= target);
  endtask

  task automatic run_until_rdreq(input int target, input int limit, output bit ok);
    int g = 0;
    while (n_rdreq < target && g < limit) begin
      cycle();
      g++;
    end
    ok = (n_rdreq >= target);
  endtask

  task automatic test_reset();
    clear_log();
    nreset = 1'b0;
    arm    = 1'b0;
    en     = 1'b1;
    repeat (2) cycle();
    vectors++;
    if (s_rdreq !== 1'b0 || s_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes rdreq=%b tx_start=%b required 0 0", s_rdreq, s_tx_start);
    end
    vectors++;
    if (s_active !== 1'b0 || s_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status active=%b frame_done=%b required 0 0", s_active, s_done);
    end
    vectors++;
    if (s_tx_byte !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_tx_byte got %02h required 00", s_tx_byte);
    end
    nreset = 1'b1;
    repeat (5) cycle();
    vectors++;
    if (n_tx != 0 || n_rdreq != 0 || s_active !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_quiet tx=%0d rd=%0d active=%b required 0 0 0", n_tx, n_rdreq, s_active);
    end
  endtask

  task automatic test_single_frame();
    bq_t s, exp;
    bit  ok;
    int  arm_cyc;
    clear_log();
    s = '{8'h01, 8'h02, 8'h03, 8'hFE};
    exp = frame_of(s);
    load_fifo(s);
    arm = 1'b1;
    cycle();
    arm_cyc = cyc;
    arm = 1'b0;
    run_until_done(1, 400, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_timeout frame_done count %0d required 1", n_done);
    end
    repeat (40) cycle();
    vectors++;
    if (sent.size() != exp.size()) begin
      miscompares++;
      $display("FAIL single_len got %0d bytes required %0d", sent.size(), exp.size());
    end
    foreach (exp[i]) begin
      vectors++;
      if (i >= sent.size() || sent[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL single_byte[%0d] got %02h required %02h", i, (i < sent.size()) ? sent[i] : 8'h00, exp[i]);
      end
    end
    vectors++;
    if (n_rdreq != 4 || n_tx != 6 || n_done != 1) begin
      miscompares++;
      $display("FAIL single_counts rdreq=%0d tx_start=%0d done=%0d required 4 6 1", n_rdreq, n_tx, n_done);
    end
    vectors++;
    if (tx_cycs.size() < 2 || rd_cycs.size() < 1 || tx_cycs[0] != arm_cyc + 1 || tx_cycs[1] != rd_cycs[0] + 2) begin
      miscompares++;
      $display("FAIL single_latency first_tx=%0d arm=%0d second_tx=%0d first_rd=%0d required +1 and +2",
               (tx_cycs.size() > 0) ? tx_cycs[0] : -1, arm_cyc,
               (tx_cycs.size() > 1) ? tx_cycs[1] : -1, (rd_cycs.size() > 0) ? rd_cycs[0] : -1);
    end
    vectors++;
    if (s_active !== 1'b0) begin
      miscompares++;
      $display("FAIL single_active_after got %b required 0", s_active);
    end
  endtask

  task automatic test_checksum_wrap();
    bq_t s, exp;
    bit  ok;
    clear_log();
    s = '{8'h80, 8'h80, 8'h80, 8'h81};
    exp = frame_of(s);
    load_fifo(s);
    arm = 1'b1;
    cycle();
    arm = 1'b0;
    run_until_done(1, 400, ok);
    repeat (5) cycle();
    vectors++;
    if (!ok || sent.size() != FL + 2) begin
      miscompares++;
      $display("FAIL wrap_len done=%0d bytes=%0d required 1 %0d", n_done, sent.size(), FL + 2);
    end
    vectors++;
    if (sent.size() == 0 || sent[sent.size()-1] !== 8'h01 || exp[FL+1] !== 8'h01) begin
      miscompares++;
      $display("FAIL wrap_csum got %02h required 01", (sent.size() > 0) ? sent[sent.size()-1] : 8'h00);
    end
  endtask

  task automatic test_underflow();
    bq_t s, first, rest, exp;
    bit  ok;
    int  tx_before, g;
    clear_log();
    s = rand_samples(FL);
    exp = frame_of(s);
    first = '{s[0], s[1]};
    rest  = '{s[2], s[3]};
    load_fifo(first);
    arm = 1'b1;
    cycle();
    arm = 1'b0;
    run_until_rdreq(2, 200, ok);
    g = 0;
    while (n_tx < 3 && g < 200) begin
      cycle();
      g++;
    end
    tx_before = n_tx;
    repeat (50) cycle();
    vectors++;
    if (n_tx != tx_before || n_rdreq != 2 || tx_before != 3) begin
      miscompares++;
      $display("FAIL underflow_stall tx %0d->%0d rdreq=%0d required 3->3 and 2", tx_before, n_tx, n_rdreq);
    end
    vectors++;
    if (s_active !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_active got %b required 1", s_active);
    end
    load_fifo(rest);
    run_until_done(1, 400, ok);
    repeat (5) cycle();
    vectors++;
    if (!ok || sent.size() != exp.size()) begin
      miscompares++;
      $display("FAIL underflow_len done=%0d bytes=%0d required 1 %0d", n_done, sent.size(), exp.size());
    end
    foreach (exp[i]) begin
      vectors++;
      if (i >= sent.size() || sent[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL underflow_byte[%0d] got %02h required %02h", i, (i < sent.size()) ? sent[i] : 8'h00, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bq_t s, exp;
    bit  ok;
    clear_log();
    for (int rep = 0; rep < 3; rep++) begin
      clear_log();
      s = rand_samples(2 * FL);
      exp = frame_of(s[0:FL-1]);
      exp = {exp, frame_of(s[FL:2*FL-1])};
      load_fifo(s);
      arm = 1'b1;
      run_until_done(2, 800, ok);
      arm = 1'b0;
      repeat (40) cycle();
      vectors++;
      if (!ok || n_done != 2 || sent.size() != exp.size()) begin
        miscompares++;
        $display("FAIL b2b_count done=%0d bytes=%0d required 2 %0d", n_done, sent.size(), exp.size());
      end
      foreach (exp[i]) begin
        vectors++;
        if (i >= sent.size() || sent[i] !== exp[i]) begin
          miscompares++;
          $display("FAIL b2b_byte[%0d] got %02h required %02h", i, (i < sent.size()) ? sent[i] : 8'h00, exp[i]);
        end
      end
      vectors++;
      if (done_cycs.size() < 1 || tx_cycs.size() <= FL + 2 || tx_cycs[FL+2] != done_cycs[0] + 2) begin
        miscompares++;
        $display("FAIL b2b_gap second header at %0d, first done at %0d, required done+2",
                 (tx_cycs.size() > FL + 2) ? tx_cycs[FL+2] : -1, (done_cycs.size() > 0) ? done_cycs[0] : -1);
      end
    end
  endtask

  task automatic test_en_gating();
    bq_t s, exp;
    bit  ok;
    int  g;
    clear_log();
    s = rand_samples(FL);
    exp = frame_of(s);
    load_fifo(s);
    en_toggle = 1'b1;
    arm = 1'b1;
    g = 0;
    do begin
      cycle();
      g++;
    end while (s_active !== 1'b1 && g < 10);
    arm = 1'b0;
    run_until_done(1, 1000, ok);
    en_toggle = 1'b0;
    en = 1'b1;
    repeat (30) cycle();
    vectors++;
    if (!ok || n_rdreq != FL || n_tx != FL + 2) begin
      miscompares++;
      $display("FAIL en_counts done=%0d rdreq=%0d tx=%0d required 1 %0d %0d", n_done, n_rdreq, n_tx, FL, FL + 2);
    end
    foreach (exp[i]) begin
      vectors++;
      if (i >= sent.size() || sent[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL en_byte[%0d] got %02h required %02h", i, (i < sent.size()) ? sent[i] : 8'h00, exp[i]);
      end
    end
  endtask

  task automatic test_reset_rearm();
    bq_t s, exp;
    bit  ok;
    int  tx_before;
    clear_log();
    s = rand_samples(FL);
    load_fifo(s);
    arm = 1'b1;
    cycle();
    arm = 1'b0;
    run_until_rdreq(3, 300, ok);
    // Hold the UART busy so the third sample parks in TX.
    force_busy = 1'b1;
    tx_busy    = 1'b1;
    tx_before  = n_tx;
    repeat (4) cycle();
    vectors++;
    if (!ok || n_tx != tx_before || tx_before != 3 || s_active !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_stall tx %0d->%0d active=%b required 3->3 and 1", tx_before, n_tx, s_active);
    end
    nreset = 1'b0;
    cycle();
    cycle();
    vectors++;
    if (s_active !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort active=%b required 0", s_active);
    end
    force_busy = 1'b0;
    repeat (3) cycle();
    vectors++;
    if (n_tx != tx_before) begin
      miscompares++;
      $display("FAIL reset_no_tx tx_start count %0d required %0d", n_tx, tx_before);
    end
    clear_log();
    s = rand_samples(FL);
    exp = frame_of(s);
    load_fifo(s);
    nreset = 1'b1;
    arm    = 1'b1;
    run_until_done(1, 400, ok);
    arm = 1'b0;
    repeat (30) cycle();
    vectors++;
    if (!ok || n_rdreq != FL || sent.size() != exp.size()) begin
      miscompares++;
      $display("FAIL rearm_counts done=%0d rdreq=%0d bytes=%0d required 1 %0d %0d",
               n_done, n_rdreq, sent.size(), FL, exp.size());
    end
    foreach (exp[i]) begin
      vectors++;
      if (i >= sent.size() || sent[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL rearm_byte[%0d] got %02h required %02h", i, (i < sent.size()) ? sent[i] : 8'h00, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_checksum_wrap();
    test_underflow();
    test_back_to_back();
    test_en_gating();
    test_reset_rearm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
